// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: clears itself to NOP_WORD after reset, serves
// registered 1-cycle fetches in RUN, and accepts MSB-first byte-stream program loads.
module instr_mem_loadable #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    Add,
  input  logic                           fetch_req,
  output logic [31:0]                    Instr,
  output logic                           instr_valid,
  output logic                           misaligned,
  output logic                           out_of_range,
  output logic                           busy,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [7:0]                     load_byte,
  input  logic                           load_end,
  output logic [$clog2(DEPTH+1)-1:0]     load_count,
  output logic                           load_err
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LCW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_LOAD
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic [LCW-1:0]  wptr_q, wptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [31:0]     asm_q, asm_d;
  logic            err_q, err_d;
  logic            auto_q, auto_d;

  logic [31:0]     instr_q;
  logic            valid_q, mis_q, oor_q;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_q [DEPTH];

  logic            fetch_mis, fetch_oor;

  assign fetch_mis = |Add[1:0];
  assign fetch_oor = |Add[31:AW+2];

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    err_d     = err_q;
    auto_d    = auto_q;
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = NOP_WORD;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH-1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          auto_d  = 1'b0;
        end else if (load_valid && auto_q) begin
          // Bytes arriving after the memory filled up are dropped but flagged.
          err_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          wptr_d = '0;
          cnt_d  = '0;
          err_d  = 1'b0;
          auto_d = 1'b0;
        end else begin
          if (load_valid) begin
            asm_d = {asm_q[23:0], load_byte};
            if (cnt_q == 2'd3) begin
              mem_we    = 1'b1;
              mem_waddr = wptr_q[AW-1:0];
              mem_wdata = asm_d;
              wptr_d    = wptr_q + LCW'(1);
            end
            cnt_d = cnt_q + 2'd1;
          end
          // The byte is consumed before load_end / full are judged.
          if (wptr_d == LCW'(DEPTH)) begin
            state_d = ST_RUN;
            auto_d  = 1'b1;
          end else if (load_end) begin
            state_d = ST_RUN;
            if (cnt_d != 2'd0) err_d = 1'b1;
            cnt_d = '0;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      asm_q     <= '0;
      err_q     <= 1'b0;
      auto_q    <= 1'b0;
      instr_q   <= NOP_WORD;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      err_q     <= err_d;
      auto_q    <= auto_d;
      if (state_q == ST_RUN && fetch_req) begin
        valid_q <= 1'b1;
        mis_q   <= fetch_mis;
        oor_q   <= fetch_oor;
        instr_q <= (fetch_mis || fetch_oor) ? NOP_WORD : mem_q[Add[AW+1:2]];
      end else begin
        valid_q <= 1'b0;
        mis_q   <= 1'b0;
        oor_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
  end

  assign Instr        = instr_q;
  assign instr_valid  = valid_q;
  assign misaligned   = mis_q;
  assign out_of_range = oor_q;
  assign busy         = (state_q != ST_RUN);
  assign load_count   = wptr_q;
  assign load_err     = err_q;

endmodule
